// File: rtl/wb_fbmem_pkg.sv
// rtl/wb_fbmem_pkg.sv - shared types for the framebuffer responder pipeline
package wb_fbmem_pkg;

  localparam int MAX_LATENCY = 4;

  typedef struct packed {
    logic valid;
    logic err;
    logic rd;
  } stage_t;

  // A stage only carries fresh read data forward when it holds a good read.
  function automatic logic read_hit(stage_t s);
    return s.valid && s.rd && !s.err;
  endfunction

endpackage

// File: rtl/wb_fbmem_if.sv
// rtl/wb_fbmem_if.sv - pipelined Wishbone bus bundle for the framebuffer responder
interface wb_fbmem_if #(
  parameter int AW = 24,
  parameter int DW = 32
) ();

  logic            i_wb_cyc;
  logic            i_wb_stb;
  logic            i_wb_we;
  logic [AW-1:0]   i_wb_addr;
  logic [DW-1:0]   i_wb_data;
  logic [DW/8-1:0] i_wb_sel;
  logic            o_wb_stall;
  logic            o_wb_ack;
  logic [DW-1:0]   o_wb_data;
  logic            o_wb_err;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_data, o_wb_err
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_data, o_wb_err
  );

endinterface

// File: rtl/wb_fbmem_ram.sv
// rtl/wb_fbmem_ram.sv - byte-enable block RAM with one-clock registered read
module wb_fbmem_ram #(
  parameter int    DW        = 32,
  parameter int    LGMEMSZ   = 12,
  parameter string INIT_FILE = ""
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [LGMEMSZ-1:0] i_addr,
  input  logic [DW-1:0]      i_data,
  input  logic [DW/8-1:0]    i_sel,
  output logic [DW-1:0]      o_data
);

  logic [DW-1:0] mem [0:(1<<LGMEMSZ)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_sel[b]) mem[i_addr][b*8 +: 8] <= i_data[b*8 +: 8];
      end
    end
  end

  // Output register only moves on reads, so the last read word is held across writes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  o_data <= '0;
    else if (i_re)   o_data <= mem[i_addr];
  end

endmodule

// File: rtl/wb_fbmem.sv
// rtl/wb_fbmem.sv - pipelined Wishbone framebuffer responder: fixed latency, periodic stall, range error
module wb_fbmem
  import wb_fbmem_pkg::*;
#(
  parameter int    AW        = 24,
  parameter int    DW        = 32,
  parameter int    LGMEMSZ   = 12,
  parameter int    LATENCY   = 2,
  parameter int    LGSTALL   = 0,
  parameter string INIT_FILE = ""
) (
  input  logic      i_clk,
  input  logic      i_reset_n,
  wb_fbmem_if.slave wb
);

  logic          stall;
  logic          bad;
  logic          flush;
  logic          take;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] rdata;
  stage_t        stg [1:LATENCY];

  if (LGSTALL == 0) begin : g_nostall
    assign stall = 1'b0;
  end else begin : g_stall
    logic [LGSTALL-1:0] cnt;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) cnt <= '0;
      else            cnt <= cnt + LGSTALL'(1);
    end
    assign stall = &cnt;
  end

  if (AW > LGMEMSZ) begin : g_range
    assign bad = |wb.i_wb_addr[AW-1:LGMEMSZ];
  end else begin : g_norange
    assign bad = 1'b0;
  end

  // An error response ends the burst: nothing queued behind it, nor accepted beside it, survives.
  assign flush = stg[LATENCY].valid && stg[LATENCY].err;
  assign take  = wb.i_wb_cyc && wb.i_wb_stb && !stall && !flush;

  wb_fbmem_ram #(
    .DW        (DW),
    .LGMEMSZ   (LGMEMSZ),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (take && !bad && wb.i_wb_we),
    .i_re      (take && !bad && !wb.i_wb_we),
    .i_addr    (wb.i_wb_addr[LGMEMSZ-1:0]),
    .i_data    (wb.i_wb_data),
    .i_sel     (wb.i_wb_sel),
    .o_data    (ram_q)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 1; k <= LATENCY; k++) stg[k] <= '0;
    end else if (!wb.i_wb_cyc || flush) begin
      for (int k = 1; k <= LATENCY; k++) stg[k] <= '0;
    end else begin
      stg[1] <= '{valid: take, err: bad, rd: !wb.i_wb_we};
      for (int k = 2; k <= LATENCY; k++) stg[k] <= stg[k-1];
    end
  end

  if (LATENCY == 1) begin : g_lat1
    assign rdata = ram_q;
  end else begin : g_latn
    logic [DW-1:0] dat [2:LATENCY];
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        for (int k = 2; k <= LATENCY; k++) dat[k] <= '0;
      end else begin
        if (read_hit(stg[1])) dat[2] <= ram_q;
        for (int k = 3; k <= LATENCY; k++) begin
          if (read_hit(stg[k-1])) dat[k] <= dat[k-1];
        end
      end
    end
    assign rdata = dat[LATENCY];
  end

  assign wb.o_wb_stall = stall;
  assign wb.o_wb_ack   = wb.i_wb_cyc && stg[LATENCY].valid && !stg[LATENCY].err;
  assign wb.o_wb_err   = wb.i_wb_cyc && stg[LATENCY].valid && stg[LATENCY].err;
  assign wb.o_wb_data  = rdata;

endmodule
